rnl_neuron: RTL and testbench
=============================

RNL_NEURON -- requirements
Module: rnl_neuron

Interface
REQ-001 Parameter N_INPUTS, default 4: number of synaptic inputs.
REQ-002 Parameter WEIGHT_WIDTH, default 3: bits per synaptic weight.
REQ-003 Parameter THRESHOLD, default 6: firing threshold, legal range 1 to N_INPUTS*(2^WEIGHT_WIDTH-1).
REQ-004 Parameter GAMMA_CYCLE_WIDTH, default 16: aclk edges per gamma cycle, power of 2.
REQ-005 Port aclk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port grst, input, 1: synchronous gamma-cycle start, sampled on aclk.
REQ-008 Port in, input, N_INPUTS: per-synapse spike levels; a rising edge marks spike time, held high until the next gamma cycle.
REQ-009 Port weights, input, N_INPUTS*WEIGHT_WIDTH: weight i in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH], unsigned.
REQ-010 Port out, output, 1: neuron spike level; rises once per gamma cycle and holds until grst or reset.
REQ-011 Port spike_time, output, clog2(GAMMA_CYCLE_WIDTH): cycle index of the firing edge.
REQ-012 Port spike_valid, output, 1: high while spike_time holds a valid value for the current gamma cycle.

Function
REQ-013 State machine SHALL have states IDLE, INTEGRATE and FIRED.
REQ-014 IDLE->INTEGRATE on grst; INTEGRATE->FIRED on threshold crossing; FIRED->INTEGRATE on grst; INTEGRATE->INTEGRATE on grst.
REQ-015 On a grst edge: latch weights into internal registers, clear all ramp counters, the potential and the cycle counter, and drive out and spike_valid to 0.
REQ-016 The latched weights SHALL be the only weights used for the whole gamma cycle; changes on the weights port between grst edges SHALL be ignored.
REQ-017 Cycle counter: 0 on the grst edge, +1 on each later edge, saturating at GAMMA_CYCLE_WIDTH-1 (no wrap).
REQ-018 Ramp counter r_i, WEIGHT_WIDTH bits, per input: in INTEGRATE or FIRED, increments on an edge where in[i]=1 and r_i < latched w_i; otherwise it holds.
REQ-019 Potential width: clog2(N_INPUTS*(2^WEIGHT_WIDTH-1)+1) bits; pot_next = pot + count of inputs incrementing this edge; overflow impossible by construction.
REQ-020 Inputs with weight 0 SHALL never contribute.
REQ-021 Fire condition, INTEGRATE only: pot_next >= THRESHOLD at an edge without grst.
REQ-022 On the fire edge: out<=1, spike_valid<=1, spike_time<=current (pre-increment) cycle count, state<=FIRED.
REQ-023 Latency: an input sampled high on edge e that completes the crossing SHALL raise out after edge e, zero added cycles.
REQ-024 FIRED: ramps and potential keep integrating, but out, spike_time and spike_valid SHALL hold; at most one fire per gamma cycle.
REQ-025 grst and a fire condition on the same edge: grst wins; no fire, clear per REQ-015.
REQ-026 IDLE: inputs are ignored; out stays 0.
REQ-027 Saturated cycle counter: a later fire records GAMMA_CYCLE_WIDTH-1.

Reset
REQ-028 rst_n low SHALL immediately set: state IDLE; out=0; spike_valid=0; spike_time=0; potential, ramps, cycle counter and latched weights all 0.
REQ-029 Deassertion of rst_n SHALL require a grst before any integration occurs.

Verification (N_INPUTS=4, WEIGHT_WIDTH=3, THRESHOLD=6)
REQ-030 Slow ramp: weights all 7, grst; in[0] high from cycle 0 -> potential 1..6, out rises after edge with cycle=5, spike_time=5.
REQ-031 Subthreshold: w0=w1=2, others 0; in[0], in[1] high from cycle 0 -> potential 2,4 then holds at 4; out=0 and spike_valid=0 through cycle 15.
REQ-032 Coincidence: w0..w2=2; in[2:0] high at cycle 0 -> potential 3,6; fire at cycle 1, spike_time=1; out held high to cycle 15.
REQ-033 Gamma restart: after REQ-032, grst together with a pending crossing -> out=0, spike_valid=0, potential 0, no fire that edge; new weights take effect.
REQ-034 Async reset mid-INTEGRATE, potential=4: rst_n low between edges -> out/spike_valid 0 at once; inputs high after release without grst -> no fire.
REQ-035 Weight change mid-cycle: weights port changed to 0 after grst -> REQ-030 result unchanged (spike_time=5).

Source files
------------

// File: rtl/rnl_neuron_if.sv
// Synapse/spike bundle for rnl_neuron: gamma-cycle control and weights in,
// spike level and timestamp out.
interface rnl_neuron_if #(
   parameter int N_INPUTS          = 4,
   parameter int WEIGHT_WIDTH      = 3,
   parameter int GAMMA_CYCLE_WIDTH = 16
);
   logic                                 grst;
   logic [N_INPUTS-1:0]                  in;
   logic [N_INPUTS*WEIGHT_WIDTH-1:0]     weights;
   logic                                 out;
   logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] spike_time;
   logic                                 spike_valid;

   modport master (
      output grst, in, weights,
      input  out, spike_time, spike_valid
   );

   modport slave (
      input  grst, in, weights,
      output out, spike_time, spike_valid
   );
endinterface

// File: rtl/rnl_neuron.sv
// Race-logic neuron: each synapse ramps the potential by one per cycle for up to
// its weight once spiked; the first threshold crossing in a gamma cycle fires.
module rnl_neuron #(
   parameter int N_INPUTS          = 4,
   parameter int WEIGHT_WIDTH      = 3,
   parameter int THRESHOLD         = 6,
   parameter int GAMMA_CYCLE_WIDTH = 16
) (
   input logic          aclk,
   input logic          rst_n,
   rnl_neuron_if.slave  bus
);
   localparam int ST_W  = $clog2(GAMMA_CYCLE_WIDTH);
   localparam int POT_W = $clog2(N_INPUTS * ((1 << WEIGHT_WIDTH) - 1) + 1);
   localparam logic [POT_W-1:0] TH      = POT_W'(THRESHOLD);
   localparam logic [ST_W-1:0]  CYC_MAX = ST_W'(GAMMA_CYCLE_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, INTEGRATE, FIRED} state_t;

   state_t                  r_state;
   logic [WEIGHT_WIDTH-1:0] r_w    [N_INPUTS];
   logic [WEIGHT_WIDTH-1:0] r_ramp [N_INPUTS];
   logic [POT_W-1:0]        r_pot;
   logic [ST_W-1:0]         r_cycle;
   logic                    r_out;
   logic                    r_valid;
   logic [ST_W-1:0]         r_spike_time;

   logic [N_INPUTS-1:0]     w_inc;
   logic [POT_W-1:0]        w_cnt;
   logic [POT_W-1:0]        w_pot_next;
   logic                    w_fire;

   // A zero weight never increments since r_ramp < 0 is impossible.
   always_comb begin
      w_cnt = '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
         w_inc[i] = bus.in[i] && (r_ramp[i] < r_w[i]);
         w_cnt    = w_cnt + POT_W'(w_inc[i]);
      end
      w_pot_next = r_pot + w_cnt;
      w_fire     = (r_state == INTEGRATE) && !bus.grst && (w_pot_next >= TH);
   end

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pot        <= '0;
         r_cycle      <= '0;
         r_out        <= 1'b0;
         r_valid      <= 1'b0;
         r_spike_time <= '0;
         for (int unsigned i = 0; i < N_INPUTS; i++) begin
            r_w[i]    <= '0;
            r_ramp[i] <= '0;
         end
      end else if (bus.grst) begin
         r_state <= INTEGRATE;
         r_pot   <= '0;
         r_cycle <= '0;
         r_out   <= 1'b0;
         r_valid <= 1'b0;
         for (int unsigned i = 0; i < N_INPUTS; i++) begin
            r_w[i]    <= bus.weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            r_ramp[i] <= '0;
         end
      end else if (r_state != IDLE) begin
         if (r_cycle != CYC_MAX)
            r_cycle <= r_cycle + 1'b1;
         r_pot <= w_pot_next;
         for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (w_inc[i])
               r_ramp[i] <= r_ramp[i] + 1'b1;
         end
         // Timestamp is the pre-increment count; FIRED keeps integrating but never re-fires.
         if (w_fire) begin
            r_state      <= FIRED;
            r_out        <= 1'b1;
            r_valid      <= 1'b1;
            r_spike_time <= r_cycle;
         end
      end
   end

   assign bus.out         = r_out;
   assign bus.spike_valid = r_valid;
   assign bus.spike_time  = r_spike_time;
endmodule

// File: tb/tb_rnl_neuron.sv
// Bench for rnl_neuron: directed scenarios plus random gamma cycles, checked
// against a closed-form potential model (sum of min(weight, edges since spike)).
module tb_rnl_neuron;
   localparam int N   = 4;
   localparam int WW  = 3;
   localparam int TH  = 6;
   localparam int G   = 16;
   localparam int STW = $clog2(G);

   logic aclk = 1'b0;
   logic rst_n;
   always #5 aclk = ~aclk;

   rnl_neuron_if #(.N_INPUTS(N), .WEIGHT_WIDTH(WW), .GAMMA_CYCLE_WIDTH(G)) bus();

   rnl_neuron #(
      .N_INPUTS(N), .WEIGHT_WIDTH(WW), .THRESHOLD(TH), .GAMMA_CYCLE_WIDTH(G)
   ) dut (
      .aclk(aclk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== 32'(exp)) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Edge index (since grst) at which the potential first reaches TH, or -1.
   function automatic int model_fire(input int w[N], input int a[N], input int len);
      for (int t = 0; t < len; t++) begin
         int pot = 0;
         for (int i = 0; i < N; i++)
            if (a[i] >= 0 && t >= a[i])
               pot += (t - a[i] + 1 < w[i]) ? (t - a[i] + 1) : w[i];
         if (pot >= TH) return t;
      end
      return -1;
   endfunction

   // wmode: 0 hold weights, 1 drive zeros after grst, 2 drive random after grst
   task automatic run_gamma(input string name, input int w[N], input int a[N], input int len,
                            input logic [N-1:0] grst_in, input int wmode);
      logic [N*WW-1:0] wp;
      int fire;
      bit exp_out;
      for (int i = 0; i < N; i++) wp[i*WW +: WW] = WW'(w[i]);
      fire = model_fire(w, a, len);
      bus.grst    = 1'b1;
      bus.weights = wp;
      bus.in      = grst_in;
      @(posedge aclk); #1;
      check_eq({name, ":grst_out"},   32'(bus.out), 0);
      check_eq({name, ":grst_valid"}, 32'(bus.spike_valid), 0);
      bus.grst = 1'b0;
      for (int t = 0; t < len; t++) begin
         for (int i = 0; i < N; i++) bus.in[i] = (a[i] >= 0 && t >= a[i]);
         bus.weights = (wmode == 0) ? wp : (wmode == 1) ? '0 : (N*WW)'($urandom);
         @(posedge aclk); #1;
         exp_out = (fire >= 0 && t >= fire);
         check_eq($sformatf("%s:out@%0d", name, t),   32'(bus.out), int'(exp_out));
         check_eq($sformatf("%s:valid@%0d", name, t), 32'(bus.spike_valid), int'(exp_out));
         if (exp_out)
            check_eq($sformatf("%s:time@%0d", name, t), 32'(bus.spike_time),
                     (fire < G - 1) ? fire : G - 1);
      end
   endtask

   task automatic async_reset_check(input string name);
      @(negedge aclk);
      rst_n = 1'b0;
      #1;
      check_eq({name, ":out"},   32'(bus.out), 0);
      check_eq({name, ":valid"}, 32'(bus.spike_valid), 0);
      check_eq({name, ":time"},  32'(bus.spike_time), 0);
      @(negedge aclk);
      rst_n       = 1'b1;
      bus.in      = '1;
      bus.weights = '1;
      repeat (10) begin
         @(posedge aclk); #1;
         check_eq({name, ":nogrst_out"}, 32'(bus.out), 0);
      end
   endtask

   initial begin
      int w[N];
      int a[N];
      rst_n       = 1'b0;
      bus.grst    = 1'b0;
      bus.in      = '0;
      bus.weights = '0;
      repeat (2) @(posedge aclk);
      #1;
      check_eq("reset_out",   32'(bus.out), 0);
      check_eq("reset_valid", 32'(bus.spike_valid), 0);
      check_eq("reset_time",  32'(bus.spike_time), 0);

      // Without a grst the neuron stays idle even with every input high.
      rst_n       = 1'b1;
      bus.in      = '1;
      bus.weights = '1;
      repeat (5) begin
         @(posedge aclk); #1;
         check_eq("idle_out", 32'(bus.out), 0);
      end

      w = '{7, 7, 7, 7}; a = '{0, -1, -1, -1};
      run_gamma("slow_ramp", w, a, 16, 4'b0000, 0);
      check_eq("slow_ramp:final_time", 32'(bus.spike_time), 5);
      run_gamma("weight_change", w, a, 16, 4'b1111, 1);
      check_eq("weight_change:final_time", 32'(bus.spike_time), 5);

      w = '{2, 2, 0, 0}; a = '{0, 0, 0, 0};
      run_gamma("subthreshold", w, a, 16, 4'b0000, 2);
      check_eq("subthreshold:final_out", 32'(bus.out), 0);

      w = '{2, 2, 2, 0}; a = '{0, 0, 0, -1};
      run_gamma("coincidence", w, a, 16, 4'b0000, 0);
      check_eq("coincidence:final_time", 32'(bus.spike_time), 1);
      check_eq("coincidence:final_out",  32'(bus.out), 1);

      // Leave potential at 3 in INTEGRATE, then grst with inputs that would cross.
      run_gamma("pending", w, a, 1, 4'b0000, 0);
      w = '{7, 7, 7, 7}; a = '{-1, -1, -1, -1};
      run_gamma("grst_wins", w, a, 4, 4'b0111, 0);
      w = '{1, 1, 1, 1}; a = '{0, 0, 0, 0};
      run_gamma("new_weights", w, a, 6, 4'b0000, 2);

      w = '{2, 2, 2, 0}; a = '{0, 0, 0, -1};
      run_gamma("pre_reset_fired", w, a, 4, 4'b0000, 0);
      async_reset_check("areset_fired");
      w = '{2, 2, 0, 0}; a = '{0, 0, -1, -1};
      run_gamma("pre_reset_pot4", w, a, 3, 4'b0000, 0);
      async_reset_check("areset_pot4");

      // Late spike with full weights: crossing after the counter saturates.
      w = '{7, 0, 0, 0}; a = '{14, -1, -1, -1};
      run_gamma("saturate", w, a, 24, 4'b0000, 0);

      for (int k = 0; k < 60; k++) begin
         int len;
         len = int'($urandom_range(24, 1));
         for (int i = 0; i < N; i++) begin
            w[i] = int'($urandom_range(7, 0));
            a[i] = int'($urandom_range(len, 0)) - 1;
            if (a[i] >= 0 && $urandom_range(3, 0) == 0) a[i] = -1;
         end
         run_gamma($sformatf("rand%0d", k), w, a, len, 4'($urandom), int'($urandom_range(2, 0)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
